// File: rtl/freq_meas_pkg.sv
// Shared FSM state type and default widths for the frequency measurement core.
`timescale 1ns/1ps
package freq_meas_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned GATE_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/freq_edge_sync.sv
// Conditions sig_in and emits a one-cycle pulse on each rising edge.
// FREQ_MEAS_SYNC_EN: adds a 2-flop synchronizer in front of the edge detector
// (rise lags the input by 3 cycles instead of 1).
`timescale 1ns/1ps
module freq_edge_sync (
    input  logic i_aclk,
    input  logic i_areset,
    input  logic i_sig,
    output logic o_rise
);

    logic w_cond;
    logic r_prev;
    logic r_rise;

`ifdef FREQ_MEAS_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer for an asynchronous sensor input
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_sig};
        end
    end

    assign w_cond = r_sync[1];
`else
    assign w_cond = i_sig;
`endif

    // Registered 0->1 detector on the conditioned signal
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= w_cond;
            r_rise <= w_cond & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/freq_meas_core.sv
// Gated rising-edge counter: counts edges of sig_in over gate_cycles ACLK cycles.
// Optional macro FREQ_MEAS_SYNC_EN (handled in freq_edge_sync) synchronizes sig_in.
`timescale 1ns/1ps
module freq_meas_core
    import freq_meas_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned GATE_W = GATE_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              sig_in,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  result,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf_flag;
    logic                r_busy;
    logic                r_valid;
    logic [CNT_W-1:0]    r_result;
    logic                r_ovf;
    logic                w_rise;

    freq_edge_sync u_edge_sync (
        .i_aclk   (ACLK),
        .i_areset (ARESET),
        .i_sig    (sig_in),
        .o_rise   (w_rise)
    );

    // Measurement FSM: arm on start, count rises for the gate window, publish result
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (gate_cycles != '0)) begin
                        r_state    <= GATE;
                        r_gate_cnt <= gate_cycles;
                        r_edge_cnt <= '0;
                        r_ovf_flag <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                GATE: begin
                    if (abort) begin
                        // abort wins over completion; result/ovf untouched
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - GATE_W'(1);
                        if (w_rise) begin
                            if (r_edge_cnt == CNT_MAX) begin
                                r_ovf_flag <= 1'b1;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                            end
                        end
                        if (r_gate_cnt == GATE_W'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_result <= r_edge_cnt;
                    r_ovf    <= r_ovf_flag;
                    r_valid  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign result = r_result;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_freq_meas_core.sv
// Bench for freq_meas_core: a 32-bit and a 4-bit (saturating) instance share stimulus
// and are compared every cycle against a window-sum model of the sampled input.
`timescale 1ns/1ps
module tb_freq_meas_core;

`ifdef FREQ_MEAS_SYNC_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 1;
`endif
    localparam int HMAX = 16384;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b1;
    logic        sig_in = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [31:0] gate_cycles = 32'd0;

    logic        busy, valid, ovf;
    logic [31:0] result;
    logic        busy4, valid4, ovf4;
    logic [3:0]  result4;

    freq_meas_core #(.CNT_W(32), .GATE_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig_in), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .busy(busy), .valid(valid), .result(result), .ovf(ovf)
    );

    freq_meas_core #(.CNT_W(4), .GATE_W(32)) dut_sat (
        .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig_in), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .busy(busy4), .valid(valid4), .result(result4), .ovf(ovf4)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // sig_in generator: 0 = constant level, 1 = toggle every sig_half cycles, 2 = random
    int   sig_mode  = 0;
    int   sig_half  = 5;
    logic sig_level = 1'b0;
    int   sig_ctr   = 0;
    always @(negedge ACLK) begin
        #1;
        case (sig_mode)
            1: begin
                sig_ctr++;
                if (sig_ctr >= sig_half) begin
                    sig_ctr = 0;
                    sig_in  = ~sig_in;
                end
            end
            2:       sig_in = 1'($urandom_range(0, 1));
            default: sig_in = sig_level;
        endcase
    end

    // ---------------- behavioural model ----------------
    bit     hist [HMAX];
    int     e        = -1;
    int     last_rst = -1;
    bit     m_active = 1'b0;
    int     m_e0     = 0;
    int     m_n      = 0;
    longint m_res    = 0;
    longint m_res4   = 0;
    bit     m_ovf    = 1'b0;
    bit     m_ovf4   = 1'b0;
    bit     m_busy   = 1'b0;
    bit     m_valid  = 1'b0;

    function automatic bit hv(input int j);
        if (j < 0 || j <= last_rst || j >= HMAX) return 1'b0;
        return hist[j];
    endfunction

    // rise pulse visible right after sampling edge k
    function automatic bit rise_at(input int k);
        return hv(k - LAG + 1) & ~hv(k - LAG);
    endfunction

    // edges counted by a window started at edge e0 lasting n cycles
    function automatic longint count_window(input int e0, input int n);
        longint c = 0;
        for (int k = e0; k < e0 + n; k++) c += longint'(rise_at(k));
        return c;
    endfunction

    always @(posedge ACLK) begin
        e++;
        if (ARESET) begin
            if (e < HMAX) hist[e] = 1'b0;
            last_rst = e;
            m_active = 1'b0;
            m_res = 0; m_res4 = 0; m_ovf = 1'b0; m_ovf4 = 1'b0;
            m_busy = 1'b0; m_valid = 1'b0;
        end else begin
            if (e < HMAX) hist[e] = sig_in;
            m_valid = 1'b0;
            if (m_active) begin
                if (e == m_e0 + m_n + 1) begin
                    m_res   = count_window(m_e0, m_n);
                    m_ovf   = (m_res > 64'sd4294967295);
                    if (m_ovf) m_res = 64'sd4294967295;
                    m_ovf4  = (m_res > 15);
                    m_res4  = m_ovf4 ? 15 : m_res;
                    m_valid = 1'b1;
                    m_active = 1'b0;
                end else if (abort && e > m_e0 && e <= m_e0 + m_n) begin
                    m_active = 1'b0;
                end
            end else if (start && gate_cycles != 32'd0) begin
                m_active = 1'b1;
                m_e0 = e;
                m_n  = int'(gate_cycles);
            end
            m_busy = m_active && (e < m_e0 + m_n);
        end
        #1;
        chk("busy32",   64'(busy),    64'(m_busy));
        chk("valid32",  64'(valid),   64'(m_valid));
        chk("result32", 64'(result),  64'(m_res));
        chk("ovf32",    64'(ovf),     64'(m_ovf));
        chk("busy4",    64'(busy4),   64'(m_busy));
        chk("valid4",   64'(valid4),  64'(m_valid));
        chk("result4",  64'(result4), 64'(m_res4));
        chk("ovf4",     64'(ovf4),    64'(m_ovf4));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input int g);
        @(negedge ACLK);
        start = 1'b1;
        gate_cycles = 32'(g);
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int cyc);
        cyc = 0;
        while (valid !== 1'b1 && cyc < bound) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("valid_seen", 64'(valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nv;
        int g;
        int ab;

        repeat (3) @(negedge ACLK);
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_valid",  64'(valid),  64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf",    64'(ovf),    64'd0);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);

        // nominal: period 10, gate 1000 -> 100 edges, valid 1001 cycles after start
        sig_mode = 1; sig_half = 5;
        pulse_start(1000);
        wait_valid(1100, cyc);
        chk("nom_latency", 64'(cyc),    64'd1001);
        chk("nom_result",  64'(result), 64'd100);
        chk("nom_ovf",     64'(ovf),    64'd0);

        // saturation: period 2, gate 64 -> 32 edges, 4-bit counter clips at 15
        sig_half = 1;
        repeat (4) @(negedge ACLK);
        pulse_start(64);
        wait_valid(100, cyc);
        chk("sat_result4",  64'(result4), 64'd15);
        chk("sat_ovf4",     64'(ovf4),    64'd1);
        chk("sat_result32", 64'(result),  64'd32);
        chk("sat_ovf32",    64'(ovf),     64'd0);

        // abort 10 cycles after start
        pulse_start(100);
        repeat (9) @(negedge ACLK);
        chk("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("abort_busy_after", 64'(busy), 64'd0);
        nv = 0;
        repeat (120) begin
            @(negedge ACLK);
            if (valid === 1'b1) nv++;
        end
        chk("abort_no_valid", 64'(nv),     64'd0);
        chk("abort_result",   64'(result), 64'd32);

        // zero gate ignored, then a start during GATE ignored
        pulse_start(0);
        repeat (4) begin
            @(negedge ACLK);
            chk("zero_gate_busy", 64'(busy), 64'd0);
        end
        sig_mode = 2;
        pulse_start(50);
        repeat (10) @(negedge ACLK);
        pulse_start(30);
        nv = 0;
        repeat (80) begin
            @(negedge ACLK);
            if (valid === 1'b1) nv++;
        end
        chk("restart_single_valid", 64'(nv), 64'd1);

        // reset mid-window, then measure a constant input
        sig_mode = 0; sig_level = 1'b1;
        pulse_start(100);
        repeat (20) @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk("rst_mid_busy",    64'(busy),   64'd0);
        chk("rst_mid_result",  64'(result), 64'd0);
        chk("rst_mid_result4", 64'(result4), 64'd0);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (5) @(negedge ACLK);
        pulse_start(20);
        wait_valid(40, cyc);
        chk("rst_const_result", 64'(result), 64'd0);
        chk("rst_const_ovf",    64'(ovf),    64'd0);

        // a single rise landing in the last of 4 gate cycles is counted
        sig_level = 1'b0;
        repeat (6) @(negedge ACLK);
        pulse_start(4);
        repeat (3 - LAG) @(negedge ACLK);
        sig_level = 1'b1;
        wait_valid(20, cyc);
        chk("last_edge_result", 64'(result), 64'd1);

        // randomized windows with stray starts and occasional aborts
        for (int t = 0; t < 8; t++) begin
            sig_mode  = int'($urandom_range(1, 2));
            sig_half  = int'($urandom_range(1, 7));
            g         = int'($urandom_range(1, 300));
            ab        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, g + 1)) : 0;
            pulse_start(g);
            for (int c = 1; c <= g + 3; c++) begin
                start       = ($urandom_range(0, 15) == 0);
                gate_cycles = 32'($urandom_range(0, 400));
                abort       = (c == ab);
                @(negedge ACLK);
            end
            start = 1'b0;
            abort = 1'b0;
            repeat (410) @(negedge ACLK);
        end

        repeat (5) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
